// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and sizing helpers for the page-cache fill controller.
package cache_pkg;

    // Controller sequencing: wait for a lookup, burst a page in, report it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    localparam int DEF_PAGES     = 32'sd4;
    localparam int DEF_PAGE_BITS = 32'sd8;
    localparam int DEF_ADDR_W    = 32'sd16;

    // Tag and page-index widths for the default geometry.
    localparam int TAG_W = DEF_ADDR_W - DEF_PAGE_BITS;
    localparam int IDX_W = $clog2(DEF_PAGES);

    // Tag width for an arbitrary geometry.
    function automatic int f_tag_w(input int addr_w, input int page_bits);
        return addr_w - page_bits;
    endfunction

    // Page-index width; never narrower than one bit.
    function automatic int f_idx_w(input int pages);
        return (pages > 32'sd1) ? $clog2(pages) : 32'sd1;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// CPU-side lookup, backing-memory read and cache-array write signals of the
// fill controller, bundled so the controller and its environment share one port.
interface cache_fill_ctrl_if import cache_pkg::*; #(
    parameter int PAGES     = DEF_PAGES,
    parameter int PAGE_BITS = DEF_PAGE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) ();
    localparam int IF_IDX_W = f_idx_w(PAGES);

    // CPU side
    logic                  cpu_valid;
    logic [ADDR_W-1:0]     cpu_a;
    logic                  flush;
    logic                  cpu_rdy;
    logic                  hit;
    logic [IF_IDX_W-1:0]   hit_page;

    // Backing-memory read side
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [7:0]            mem_data;

    // Cache-array write side
    logic                  fill_we;
    logic [IF_IDX_W-1:0]   fill_page;
    logic [PAGE_BITS-1:0]  fill_off;
    logic [7:0]            fill_data;

    // Environment: CPU strobe source, backing memory, cache-array sink.
    modport master (
        output cpu_valid, cpu_a, flush, mem_ack, mem_data,
        input  cpu_rdy, hit, hit_page, mem_req, mem_addr,
               fill_we, fill_page, fill_off, fill_data
    );

    // Fill controller.
    modport slave (
        input  cpu_valid, cpu_a, flush, mem_ack, mem_data,
        output cpu_rdy, hit, hit_page, mem_req, mem_addr,
               fill_we, fill_page, fill_off, fill_data
    );

endinterface

// File: rtl/cache_fill_ctrl_tag_store.sv
// Tag and valid registers for every cache page, with a parallel tag compare,
// lowest-invalid-page selection and a whole-cache invalidate.
module cache_tag_store import cache_pkg::*; #(
    parameter int PAGES   = DEF_PAGES,
    parameter int P_TAG_W = TAG_W,
    parameter int P_IDX_W = IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_TAG_W-1:0] i_lookup_tag,
    output logic               o_hit,
    output logic [P_IDX_W-1:0] o_hit_idx,
    output logic               o_any_invalid,
    output logic [P_IDX_W-1:0] o_free_idx,
    input  logic               i_set_we,
    input  logic [P_IDX_W-1:0] i_set_idx,
    input  logic [P_TAG_W-1:0] i_set_tag,
    input  logic               i_clear_all
);

    logic [P_TAG_W-1:0] r_tag [PAGES];
    logic [PAGES-1:0]   r_valid;

    logic               w_hit;
    logic [P_IDX_W-1:0] w_hit_idx;
    logic [P_IDX_W-1:0] w_free_idx;

    // Install a freshly filled page; an invalidate overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < PAGES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (i_set_we) begin
                r_tag[i_set_idx]   <= i_set_tag;
                r_valid[i_set_idx] <= 1'b1;
            end
            if (i_clear_all) begin
                r_valid <= '0;
            end
        end
    end

    // Compare every page at once; scanning downwards leaves the lowest index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            w_hit_idx  = (r_valid[i] && (r_tag[i] == i_lookup_tag)) ? P_IDX_W'(i) : w_hit_idx;
            w_hit      = w_hit | (r_valid[i] && (r_tag[i] == i_lookup_tag));
            w_free_idx = (!r_valid[i]) ? P_IDX_W'(i) : w_free_idx;
        end
    end

    assign o_hit         = w_hit;
    assign o_hit_idx     = w_hit_idx;
    assign o_free_idx    = w_free_idx;
    assign o_any_invalid = ~&r_valid;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler and page refill sequencer for the CPU-side page cache. Looks up
// each strobed CPU address, stalls the CPU on a miss, bursts the victim page in
// from backing memory and writes every byte into the cache array.
module cache_fill_ctrl import cache_pkg::*; #(
    parameter int PAGES     = DEF_PAGES,
    parameter int PAGE_BITS = DEF_PAGE_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic             fpga,
    input  logic             rst_n,
    cache_fill_ctrl_if.slave bus
);

    localparam int                   L_TAG_W   = f_tag_w(ADDR_W, PAGE_BITS);
    localparam int                   L_IDX_W   = f_idx_w(PAGES);
    localparam logic [PAGE_BITS-1:0] L_CNT_ONE = PAGE_BITS'(1'b1);
    localparam logic [L_IDX_W-1:0]   L_IDX_ONE = L_IDX_W'(1'b1);

    // State and registered outputs
    fill_state_t          r_state;
    logic [L_TAG_W-1:0]   r_tag;
    logic [L_IDX_W-1:0]   r_victim;
    logic [PAGE_BITS-1:0] r_cnt;
    logic [L_IDX_W-1:0]   r_rr;
    logic                 r_flush_pend;
    logic                 r_cpu_rdy;
    logic                 r_hit;
    logic [L_IDX_W-1:0]   r_hit_page;
    logic                 r_mem_req;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic                 r_fill_we;
    logic [L_IDX_W-1:0]   r_fill_page;
    logic [PAGE_BITS-1:0] r_fill_off;
    logic [7:0]           r_fill_data;

    // Next-state values
    fill_state_t          w_state_nxt;
    logic [L_TAG_W-1:0]   w_tag_nxt;
    logic [L_IDX_W-1:0]   w_victim_nxt;
    logic [PAGE_BITS-1:0] w_cnt_nxt;
    logic [L_IDX_W-1:0]   w_rr_nxt;
    logic                 w_flush_pend_nxt;
    logic                 w_cpu_rdy_nxt;
    logic                 w_hit_nxt;
    logic [L_IDX_W-1:0]   w_hit_page_nxt;
    logic                 w_mem_req_nxt;
    logic [ADDR_W-1:0]    w_mem_addr_nxt;
    logic                 w_fill_we_nxt;
    logic [L_IDX_W-1:0]   w_fill_page_nxt;
    logic [PAGE_BITS-1:0] w_fill_off_nxt;
    logic [7:0]           w_fill_data_nxt;

    // Tag store interface
    logic [L_TAG_W-1:0]   w_lookup_tag;
    logic                 w_store_hit;
    logic [L_IDX_W-1:0]   w_store_hit_idx;
    logic                 w_any_invalid;
    logic [L_IDX_W-1:0]   w_free_idx;
    logic                 w_set_we;
    logic                 w_clear_all;

    logic                 w_ack;
    logic [PAGE_BITS-1:0] w_cnt_inc;

    assign w_lookup_tag = bus.cpu_a[ADDR_W-1:PAGE_BITS];
    assign w_ack        = r_mem_req & bus.mem_ack;
    assign w_cnt_inc    = r_cnt + L_CNT_ONE;

    cache_tag_store #(
        .PAGES   (PAGES),
        .P_TAG_W (L_TAG_W),
        .P_IDX_W (L_IDX_W)
    ) u_tag_store (
        .clk           (fpga),
        .rst_n         (rst_n),
        .i_lookup_tag  (w_lookup_tag),
        .o_hit         (w_store_hit),
        .o_hit_idx     (w_store_hit_idx),
        .o_any_invalid (w_any_invalid),
        .o_free_idx    (w_free_idx),
        .i_set_we      (w_set_we),
        .i_set_idx     (r_victim),
        .i_set_tag     (r_tag),
        .i_clear_all   (w_clear_all)
    );

    // Next-state and next-output decode for the IDLE/FILL/DONE sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_tag_nxt        = r_tag;
        w_victim_nxt     = r_victim;
        w_cnt_nxt        = r_cnt;
        w_rr_nxt         = r_rr;
        w_flush_pend_nxt = r_flush_pend;
        w_cpu_rdy_nxt    = r_cpu_rdy;
        w_hit_nxt        = 1'b0;
        w_hit_page_nxt   = r_hit_page;
        w_mem_req_nxt    = r_mem_req;
        w_mem_addr_nxt   = r_mem_addr;
        w_fill_we_nxt    = 1'b0;
        w_fill_page_nxt  = r_fill_page;
        w_fill_off_nxt   = r_fill_off;
        w_fill_data_nxt  = r_fill_data;
        w_set_we         = 1'b0;
        w_clear_all      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cpu_rdy_nxt = 1'b1;
                w_mem_req_nxt = 1'b0;
                w_clear_all   = bus.flush;
                if (bus.cpu_valid) begin
                    // A coincident flush empties the cache, so the lookup misses.
                    if (w_store_hit && !bus.flush) begin
                        w_hit_nxt      = 1'b1;
                        w_hit_page_nxt = w_store_hit_idx;
                    end else begin
                        w_tag_nxt      = w_lookup_tag;
                        if (bus.flush) begin
                            w_victim_nxt = '0;
                        end else if (w_any_invalid) begin
                            w_victim_nxt = w_free_idx;
                        end else begin
                            w_victim_nxt = r_rr;
                        end
                        w_cnt_nxt      = '0;
                        w_mem_req_nxt  = 1'b1;
                        w_mem_addr_nxt = {w_lookup_tag, {PAGE_BITS{1'b0}}};
                        w_cpu_rdy_nxt  = 1'b0;
                        w_state_nxt    = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_FILL: begin
                // A flush mid-burst waits until the page has been reported.
                w_flush_pend_nxt = r_flush_pend | bus.flush;
                if (w_ack) begin
                    w_fill_we_nxt   = 1'b1;
                    w_fill_page_nxt = r_victim;
                    w_fill_off_nxt  = r_cnt;
                    w_fill_data_nxt = bus.mem_data;
                    w_cnt_nxt       = w_cnt_inc;
                    w_mem_addr_nxt  = {r_tag, w_cnt_inc};
                    if (r_cnt == '1) begin
                        w_mem_req_nxt  = 1'b0;
                        w_set_we       = 1'b1;
                        w_rr_nxt       = r_victim + L_IDX_ONE;
                        w_hit_nxt      = 1'b1;
                        w_hit_page_nxt = r_victim;
                        w_cpu_rdy_nxt  = 1'b1;
                        w_state_nxt    = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end

            ST_DONE: begin
                w_clear_all      = bus.flush | r_flush_pend;
                w_flush_pend_nxt = 1'b0;
                w_state_nxt      = ST_IDLE;
            end

            default: begin
                w_state_nxt      = ST_IDLE;
                w_cpu_rdy_nxt    = 1'b1;
                w_mem_req_nxt    = 1'b0;
                w_flush_pend_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns every element to its idle value.
    always_ff @(posedge fpga) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_victim     <= '0;
            r_cnt        <= '0;
            r_rr         <= '0;
            r_flush_pend <= 1'b0;
            r_cpu_rdy    <= 1'b1;
            r_hit        <= 1'b0;
            r_hit_page   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fill_we    <= 1'b0;
            r_fill_page  <= '0;
            r_fill_off   <= '0;
            r_fill_data  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_tag        <= w_tag_nxt;
            r_victim     <= w_victim_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rr         <= w_rr_nxt;
            r_flush_pend <= w_flush_pend_nxt;
            r_cpu_rdy    <= w_cpu_rdy_nxt;
            r_hit        <= w_hit_nxt;
            r_hit_page   <= w_hit_page_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_fill_we    <= w_fill_we_nxt;
            r_fill_page  <= w_fill_page_nxt;
            r_fill_off   <= w_fill_off_nxt;
            r_fill_data  <= w_fill_data_nxt;
        end
    end

    assign bus.cpu_rdy   = r_cpu_rdy;
    assign bus.hit       = r_hit;
    assign bus.hit_page  = r_hit_page;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.fill_we   = r_fill_we;
    assign bus.fill_page = r_fill_page;
    assign bus.fill_off  = r_fill_off;
    assign bus.fill_data = r_fill_data;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a 4-byte-page instance for the lookup,
// fill, round-robin, wait-state and flush scenarios and a 256-byte-page
// instance for reset in the middle of a burst.
module tb_cache_fill_ctrl;

    logic fpga = 1'b0;
    logic rst_n_s;
    logic rst_n_l;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 fpga = ~fpga;

    cache_fill_ctrl_if #(.PAGES(4), .PAGE_BITS(2), .ADDR_W(16)) bus_s ();
    cache_fill_ctrl_if #(.PAGES(4), .PAGE_BITS(8), .ADDR_W(16)) bus_l ();

    cache_fill_ctrl #(.PAGES(4), .PAGE_BITS(2), .ADDR_W(16)) u_dut_s (
        .fpga (fpga), .rst_n (rst_n_s), .bus (bus_s)
    );
    cache_fill_ctrl #(.PAGES(4), .PAGE_BITS(8), .ADDR_W(16)) u_dut_l (
        .fpga (fpga), .rst_n (rst_n_l), .bus (bus_l)
    );

    // Observations gathered by drive_fill_s for the 4-byte-page instance
    int          obs_we_n, obs_acks, obs_hold_err, obs_rdy_low, obs_rdy_early, obs_done_cycle;
    logic [1:0]  obs_we_page [4];
    logic [1:0]  obs_we_off  [4];
    logic [7:0]  obs_we_data [4];
    logic [15:0] obs_ack_addr[4];
    logic        obs_done, obs_done_rdy, obs_first_hit, obs_first_req, obs_first_rdy;
    logic [1:0]  obs_done_page;

    task automatic tick;
        @(posedge fpga);
        #1;
    endtask

    task automatic reset_s;
        rst_n_s = 1'b0;
        tick;
        tick;
        rst_n_s = 1'b1;
    endtask

    // Issue a lookup on the small instance and act as backing memory until the
    // DUT reports a hit; acks come every 'period' cycles with data d_base+cnt.
    task automatic drive_fill_s(input logic [15:0] addr, input int period, input logic [7:0] d_base,
                                input int flush_at, input logic flush_lookup);
        logic        prev_req, prev_ack, ack;
        logic [15:0] prev_addr;
        obs_we_n = 0; obs_acks = 0; obs_hold_err = 0; obs_rdy_low = 0; obs_rdy_early = 0;
        obs_done = 1'b0; obs_done_page = 2'd0; obs_done_rdy = 1'b0; obs_done_cycle = -1;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0000;
        bus_s.cpu_a = addr; bus_s.cpu_valid = 1'b1; bus_s.flush = flush_lookup;
        tick;
        bus_s.cpu_valid = 1'b0; bus_s.flush = 1'b0;
        obs_first_hit = bus_s.hit; obs_first_req = bus_s.mem_req; obs_first_rdy = bus_s.cpu_rdy;
        for (int c = 0; c < 200; c++) begin
            if (bus_s.fill_we) begin
                if (obs_we_n < 4) begin
                    obs_we_page[obs_we_n] = bus_s.fill_page;
                    obs_we_off[obs_we_n]  = bus_s.fill_off;
                    obs_we_data[obs_we_n] = bus_s.fill_data;
                end
                obs_we_n++;
            end
            if (bus_s.hit) begin
                obs_done = 1'b1; obs_done_page = bus_s.hit_page;
                obs_done_rdy = bus_s.cpu_rdy; obs_done_cycle = c;
                break;
            end
            if (bus_s.cpu_rdy) obs_rdy_early++;
            else obs_rdy_low++;
            if (prev_req && !prev_ack && bus_s.mem_req && (bus_s.mem_addr !== prev_addr)) obs_hold_err++;
            ack = (period <= 1) || ((c % period) == (period - 1));
            bus_s.mem_ack  = ack;
            bus_s.mem_data = d_base + obs_acks[7:0];
            if (ack && bus_s.mem_req) begin
                if (obs_acks < 4) obs_ack_addr[obs_acks] = bus_s.mem_addr;
                obs_acks++;
            end
            bus_s.flush = (c == flush_at);
            prev_req = bus_s.mem_req; prev_ack = ack; prev_addr = bus_s.mem_addr;
            tick;
        end
        bus_s.flush = 1'b0;
        tick;
        bus_s.mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n_s = 1'b0; rst_n_l = 1'b0;
        tick; tick;
        n_chk++; if (bus_s.cpu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_cpu_rdy: got %b want 1", bus_s.cpu_rdy); end
        n_chk++; if (bus_s.hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", bus_s.hit); end
        n_chk++; if (bus_s.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus_s.mem_req); end
        n_chk++; if (bus_s.fill_we !== 1'b0) begin n_err++; $display("FAIL reset_fill_we: got %b want 0", bus_s.fill_we); end
        n_chk++; if (bus_s.mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", bus_s.mem_addr); end
        n_chk++; if ({bus_s.hit_page, bus_s.fill_page, bus_s.fill_off, bus_s.fill_data} !== 14'h0000) begin
            n_err++; $display("FAIL reset_page_fields: got %h want 0", {bus_s.hit_page, bus_s.fill_page, bus_s.fill_off, bus_s.fill_data}); end
        n_chk++; if ({bus_l.cpu_rdy, bus_l.mem_req, bus_l.fill_we, bus_l.hit} !== 4'b1000) begin
            n_err++; $display("FAIL reset_large_ctrl: got %b want 1000", {bus_l.cpu_rdy, bus_l.mem_req, bus_l.fill_we, bus_l.hit}); end
        rst_n_s = 1'b1; rst_n_l = 1'b1;
        tick;
    endtask

    task automatic test_cold_miss;
        drive_fill_s(16'h1203, 1, 8'hA0, -1, 1'b0);
        n_chk++; if ({obs_first_req, obs_first_rdy} !== 2'b10) begin n_err++; $display("FAIL cold_first_cycle req/rdy: got %b want 10", {obs_first_req, obs_first_rdy}); end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (obs_ack_addr[k] !== (16'h1200 + k[15:0])) begin n_err++; $display("FAIL cold_mem_addr[%0d]: got %h want %h", k, obs_ack_addr[k], 16'h1200 + k[15:0]); end
            n_chk++; if ({obs_we_page[k], obs_we_off[k], obs_we_data[k]} !== {2'd0, k[1:0], 8'hA0 + k[7:0]}) begin
                n_err++; $display("FAIL cold_fill_write[%0d]: got page %0d off %0d data %h want page 0 off %0d data %h",
                                  k, obs_we_page[k], obs_we_off[k], obs_we_data[k], k, 8'hA0 + k[7:0]); end
        end
        n_chk++; if (obs_we_n !== 4) begin n_err++; $display("FAIL cold_we_count: got %0d want 4", obs_we_n); end
        n_chk++; if ({obs_done, obs_done_page, obs_done_rdy} !== 4'b1001) begin n_err++; $display("FAIL cold_done: got done %b page %0d rdy %b want 1 0 1", obs_done, obs_done_page, obs_done_rdy); end
        n_chk++; if (obs_done_cycle !== 4) begin n_err++; $display("FAIL cold_done_latency: got %0d want 4", obs_done_cycle); end
        n_chk++; if (obs_rdy_low !== 4) begin n_err++; $display("FAIL cold_rdy_low_cycles: got %0d want 4", obs_rdy_low); end
        n_chk++; if ({bus_s.mem_req, bus_s.fill_we} !== 2'b00) begin n_err++; $display("FAIL cold_ack_after_done_ignored: got %b want 00", {bus_s.mem_req, bus_s.fill_we}); end
    endtask

    task automatic test_hit_after_fill;
        bus_s.cpu_a = 16'h1201; bus_s.cpu_valid = 1'b1;
        tick;
        bus_s.cpu_valid = 1'b0;
        n_chk++; if ({bus_s.hit, bus_s.hit_page, bus_s.mem_req} !== 4'b1000) begin
            n_err++; $display("FAIL hit_after_fill: got hit %b page %0d req %b want 1 0 0", bus_s.hit, bus_s.hit_page, bus_s.mem_req); end
        tick;
        n_chk++; if ({bus_s.hit, bus_s.mem_req, bus_s.cpu_rdy} !== 3'b001) begin
            n_err++; $display("FAIL hit_pulse_width: got hit %b req %b rdy %b want 0 0 1", bus_s.hit, bus_s.mem_req, bus_s.cpu_rdy); end
    endtask

    task automatic test_round_robin;
        reset_s;
        for (int t = 0; t < 4; t++) begin
            drive_fill_s(16'(t * 4), 1, 8'h10, -1, 1'b0);
            n_chk++; if ({obs_done, obs_done_page} !== {1'b1, t[1:0]}) begin n_err++; $display("FAIL rr_cold_fill[%0d]: got done %b page %0d want 1 %0d", t, obs_done, obs_done_page, t); end
        end
        drive_fill_s(16'h0014, 1, 8'h20, -1, 1'b0);
        n_chk++; if ({obs_done, obs_done_page, obs_we_page[0]} !== 5'b10000) begin n_err++; $display("FAIL rr_tag05_page: got done %b page %0d write page %0d want 1 0 0", obs_done, obs_done_page, obs_we_page[0]); end
        drive_fill_s(16'h0018, 1, 8'h30, -1, 1'b0);
        n_chk++; if ({obs_done, obs_done_page} !== 3'b101) begin n_err++; $display("FAIL rr_tag06_page: got done %b page %0d want 1 1", obs_done, obs_done_page); end
        bus_s.cpu_a = 16'h000D; bus_s.cpu_valid = 1'b1;
        tick;
        bus_s.cpu_valid = 1'b0;
        n_chk++; if ({bus_s.hit, bus_s.hit_page} !== 3'b111) begin n_err++; $display("FAIL rr_tag03_still_hits: got hit %b page %0d want 1 3", bus_s.hit, bus_s.hit_page); end
        tick;
    endtask

    task automatic test_wait_states;
        // Pages hold tags 05,06,02,03 and rr points at page 2.
        drive_fill_s(16'h4000, 3, 8'h50, -1, 1'b0);
        n_chk++; if (obs_hold_err !== 0) begin n_err++; $display("FAIL wait_addr_hold: got %0d changes want 0", obs_hold_err); end
        n_chk++; if (obs_we_n !== 4) begin n_err++; $display("FAIL wait_we_count: got %0d want 4", obs_we_n); end
        n_chk++; if ({obs_rdy_early, obs_rdy_low} !== {32'd0, 32'd12}) begin n_err++; $display("FAIL wait_rdy: got early %0d low %0d want 0 12", obs_rdy_early, obs_rdy_low); end
        n_chk++; if ({obs_done, obs_done_page, obs_done_rdy} !== 4'b1101) begin n_err++; $display("FAIL wait_done: got done %b page %0d rdy %b want 1 2 1", obs_done, obs_done_page, obs_done_rdy); end
        n_chk++; if ({obs_ack_addr[3], obs_we_data[3]} !== {16'h4003, 8'h53}) begin n_err++; $display("FAIL wait_last_beat: got addr %h data %h want 4003 53", obs_ack_addr[3], obs_we_data[3]); end
    endtask

    task automatic test_flush_during_fill;
        // All pages valid, rr points at page 3.
        drive_fill_s(16'h2000, 1, 8'h60, 1, 1'b0);
        n_chk++; if ({obs_done, obs_done_page, obs_we_n} !== {1'b1, 2'd3, 32'd4}) begin n_err++; $display("FAIL flush_fill_done: got done %b page %0d writes %0d want 1 3 4", obs_done, obs_done_page, obs_we_n); end
        drive_fill_s(16'h2000, 1, 8'h70, -1, 1'b0);
        n_chk++; if ({obs_first_hit, obs_first_req} !== 2'b01) begin n_err++; $display("FAIL flush_relookup_miss: got hit %b req %b want 0 1", obs_first_hit, obs_first_req); end
        n_chk++; if ({obs_done, obs_done_page} !== 3'b100) begin n_err++; $display("FAIL flush_refill_page: got done %b page %0d want 1 0", obs_done, obs_done_page); end
    endtask

    task automatic test_flush_idle;
        // Page 0 holds tag of 0x2000; a coincident flush must force a miss into page 0.
        drive_fill_s(16'h2002, 1, 8'h80, -1, 1'b1);
        n_chk++; if ({obs_first_hit, obs_first_req} !== 2'b01) begin n_err++; $display("FAIL flush_idle_wins: got hit %b req %b want 0 1", obs_first_hit, obs_first_req); end
        n_chk++; if ({obs_done, obs_done_page} !== 3'b100) begin n_err++; $display("FAIL flush_idle_victim: got done %b page %0d want 1 0", obs_done, obs_done_page); end
        bus_s.cpu_a = 16'h2001; bus_s.cpu_valid = 1'b1;
        tick;
        bus_s.cpu_valid = 1'b0;
        n_chk++; if ({bus_s.hit, bus_s.hit_page} !== 3'b100) begin n_err++; $display("FAIL flush_idle_then_hit: got hit %b page %0d want 1 0", bus_s.hit, bus_s.hit_page); end
        tick;
    endtask

    task automatic test_reset_mid_fill;
        bus_l.cpu_a = 16'h3456; bus_l.cpu_valid = 1'b1;
        tick;
        bus_l.cpu_valid = 1'b0;
        n_chk++; if ({bus_l.mem_req, bus_l.cpu_rdy, bus_l.mem_addr} !== {2'b10, 16'h3400}) begin
            n_err++; $display("FAIL rst_fill_start: got req %b rdy %b addr %h want 1 0 3400", bus_l.mem_req, bus_l.cpu_rdy, bus_l.mem_addr); end
        bus_l.mem_ack = 1'b1; bus_l.mem_data = 8'h77;
        tick;
        bus_l.mem_data = 8'h78;
        tick;
        n_chk++; if ({bus_l.fill_we, bus_l.fill_off, bus_l.fill_data, bus_l.mem_addr} !== {1'b1, 8'h01, 8'h78, 16'h3402}) begin
            n_err++; $display("FAIL rst_two_acks: got we %b off %h data %h addr %h want 1 01 78 3402", bus_l.fill_we, bus_l.fill_off, bus_l.fill_data, bus_l.mem_addr); end
        bus_l.mem_ack = 1'b0; rst_n_l = 1'b0;
        tick;
        rst_n_l = 1'b1;
        n_chk++; if ({bus_l.cpu_rdy, bus_l.hit, bus_l.mem_req, bus_l.fill_we} !== 4'b1000) begin
            n_err++; $display("FAIL rst_mid_ctrl: got rdy %b hit %b req %b we %b want 1 0 0 0", bus_l.cpu_rdy, bus_l.hit, bus_l.mem_req, bus_l.fill_we); end
        n_chk++; if ({bus_l.mem_addr, bus_l.fill_page, bus_l.fill_off, bus_l.fill_data, bus_l.hit_page} !== 36'h0) begin
            n_err++; $display("FAIL rst_mid_data: got addr %h page %0d off %h data %h hit_page %0d want all 0",
                              bus_l.mem_addr, bus_l.fill_page, bus_l.fill_off, bus_l.fill_data, bus_l.hit_page); end
        tick;
        bus_l.cpu_a = 16'h3456; bus_l.cpu_valid = 1'b1;
        tick;
        bus_l.cpu_valid = 1'b0;
        n_chk++; if ({bus_l.hit, bus_l.mem_req, bus_l.mem_addr} !== {2'b01, 16'h3400}) begin
            n_err++; $display("FAIL rst_partial_invalid: got hit %b req %b addr %h want 0 1 3400", bus_l.hit, bus_l.mem_req, bus_l.mem_addr); end
        rst_n_l = 1'b0;
        tick;
        rst_n_l = 1'b1;
    endtask

    initial begin
        bus_s.cpu_valid = 1'b0; bus_s.cpu_a = 16'h0000; bus_s.flush = 1'b0;
        bus_s.mem_ack = 1'b0; bus_s.mem_data = 8'h00;
        bus_l.cpu_valid = 1'b0; bus_l.cpu_a = 16'h0000; bus_l.flush = 1'b0;
        bus_l.mem_ack = 1'b0; bus_l.mem_data = 8'h00;
        rst_n_s = 1'b0; rst_n_l = 1'b0;
        test_reset;
        test_cold_miss;
        test_hit_after_fill;
        test_round_robin;
        test_wait_states;
        test_flush_during_fill;
        test_flush_idle;
        test_reset_mid_fill;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
